// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter slice.
//   CDB_N           : results broadcast per cycle
//   NUM_FU_*        : functional-unit counts feeding the CDB
//   cdb_packet_t    : one CDB slot {valid, robn, dest_prn, value}
package cdb_arbiter_pkg;
  localparam int CDB_N       = 2;
  localparam int NUM_FU_ALU  = 3;
  localparam int NUM_FU_MULT = 2;
  localparam int NUM_FU_LOAD = 1;
  localparam int ROB_W       = 5;
  localparam int PRN_W       = 6;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] robn;
    logic [PRN_W-1:0] dest_prn;
    logic [XLEN-1:0]  value;
  } cdb_packet_t;
endpackage

// File: rtl/rr_select_n.sv
// Combinational N-of-M round-robin selector.
//   ptr      : first requester index to consider (0..M-1)
//   req      : request vector
//   grant    : one bit per granted requester (at most N set)
//   slot_vld : slot s holds a grant
//   slot_idx : requester index placed in slot s, in scan order
//   last     : index of the last requester granted (ptr when none)
//   any      : at least one grant
module rr_select_n #(
  parameter  int N  = 2,
  parameter  int M  = 6,
  localparam int PW = (M > 1) ? $clog2(M) : 1
) (
  input  logic [PW-1:0]         ptr,
  input  logic [M-1:0]          req,
  output logic [M-1:0]          grant,
  output logic [N-1:0]          slot_vld,
  output logic [N-1:0][PW-1:0]  slot_idx,
  output logic [PW-1:0]         last,
  output logic                  any
);
  int cnt;
  int idx;

  always_comb begin
    grant    = '0;
    slot_vld = '0;
    slot_idx = '0;
    last     = ptr;
    any      = 1'b0;
    cnt      = 0;
    idx      = 0;
    for (int k = 0; k < M; k++) begin
      // Wrap by subtraction so non-power-of-two M needs no divider.
      idx = int'(ptr) + k;
      if (idx >= M) idx = idx - M;
      if (req[idx] && cnt < N) begin
        grant[idx]    = 1'b1;
        slot_vld[cnt] = 1'b1;
        slot_idx[cnt] = PW'(idx);
        last          = PW'(idx);
        any           = 1'b1;
        cnt           = cnt + 1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to N completed FU results per cycle
// round-robin and broadcasts them on a registered CDB the next cycle.
//   clock, reset : posedge clock, async active-high reset
//   squash       : ROB flush; blocks grants and clears wait counters
//   req_valid    : FU i holds a completed result
//   req_packet   : result of FU i
//   req_grant    : combinational accept, FU may drop result at next edge
//   cdb_packet   : registered broadcast, slots filled from 0 in scan order
//   max_wait     : debug, longest wait seen by any request (saturating)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N       = CDB_N,
  parameter  int NUM_REQ = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic        [NUM_REQ-1:0]        req_valid,
  input  cdb_packet_t [NUM_REQ-1:0]        req_packet,
  output logic        [NUM_REQ-1:0]        req_grant,
  output cdb_packet_t [N-1:0]              cdb_packet,
  output logic        [7:0]                max_wait
);
  logic [PW-1:0]               ptr, ptr_nxt;
  logic [NUM_REQ-1:0]          req_eff, grant;
  logic [N-1:0]                slot_vld;
  logic [N-1:0][PW-1:0]        slot_idx;
  logic [PW-1:0]               last;
  logic                        any;
  cdb_packet_t [N-1:0]         cdb_nxt;
  logic [NUM_REQ-1:0][7:0]     wait_cnt, wait_nxt;
  logic [7:0]                  max_nxt;

  // Reset gates requests too so nothing is accepted while it is held.
  assign req_eff   = (squash || reset) ? '0 : req_valid;
  assign req_grant = grant;

  rr_select_n #(.N(N), .M(NUM_REQ)) u_sel (
    .ptr      (ptr),
    .req      (req_eff),
    .grant    (grant),
    .slot_vld (slot_vld),
    .slot_idx (slot_idx),
    .last     (last),
    .any      (any)
  );

  assign ptr_nxt = (last == PW'(NUM_REQ - 1)) ? '0 : last + 1'b1;

  always_comb begin
    cdb_nxt = '0;
    for (int s = 0; s < N; s++) begin
      if (slot_vld[s]) begin
        cdb_nxt[s]       = req_packet[slot_idx[s]];
        cdb_nxt[s].valid = 1'b1;
      end
    end
  end

  // A request that is not valid keeps its count; FUs only withdraw on
  // grant, which has already cleared it.
  always_comb begin
    wait_nxt = wait_cnt;
    max_nxt  = max_wait;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (squash || grant[i])
        wait_nxt[i] = 8'd0;
      else if (req_valid[i] && wait_cnt[i] != 8'hFF)
        wait_nxt[i] = wait_cnt[i] + 8'd1;
      if (wait_nxt[i] > max_nxt) max_nxt = wait_nxt[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      cdb_packet <= '0;
      wait_cnt   <= '0;
      max_wait   <= '0;
    end else begin
      if (any) ptr <= ptr_nxt;
      cdb_packet <= cdb_nxt;
      wait_cnt   <= wait_nxt;
      max_wait   <= max_nxt;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  localparam int N = 2;
  localparam int M = 6;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  squash;
  logic [M-1:0]          req_valid;
  cdb_packet_t [M-1:0]   req_packet;
  logic [M-1:0]          req_grant;
  cdb_packet_t [N-1:0]   cdb_packet;
  logic [7:0]            max_wait;

  cdb_arbiter #(.N(N), .NUM_REQ(M)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_packet(req_packet),
    .req_grant(req_grant), .cdb_packet(cdb_packet), .max_wait(max_wait)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stimulus state
  cdb_packet_t  pk[M];
  logic [M-1:0] vin;
  logic         sqin;

  // Reference model state
  int           m_ptr;
  int           m_wait[M];
  int           m_max;
  int           ex_s[N];
  logic [M-1:0] ex_g;
  logic [M-1:0] got_g;

  task automatic drive();
    for (int i = 0; i < M; i++) req_packet[i] = pk[i];
    req_valid = vin;
    squash    = sqin;
  endtask

  function automatic cdb_packet_t slot_pkt(input int fu);
    cdb_packet_t p;
    if (fu < 0) return '0;
    p = pk[fu];
    p.valid = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_max = 0;
    for (int i = 0; i < M; i++) m_wait[i] = 0;
  endtask

  // One arbitration cycle; inputs must already be driven.
  task automatic step();
    int cnt;
    int last;
    int idx;
    cdb_packet_t ex[N];
    cnt  = 0;
    last = -1;
    @(negedge clock);
    ex_g = '0;
    for (int s = 0; s < N; s++) ex_s[s] = -1;
    if (!sqin) begin
      for (int k = 0; k < M; k++) begin
        idx = (m_ptr + k) % M;
        if (vin[idx] && cnt < N) begin
          ex_g[idx] = 1'b1;
          ex_s[cnt] = idx;
          cnt++;
          last = idx;
        end
      end
    end
    got_g = req_grant;
    chk("req_grant", req_grant, ex_g);
    for (int s = 0; s < N; s++) ex[s] = slot_pkt(ex_s[s]);
    for (int i = 0; i < M; i++) begin
      if (sqin || ex_g[i]) m_wait[i] = 0;
      else if (vin[i] && m_wait[i] < 255) m_wait[i]++;
      if (m_wait[i] > m_max) m_max = m_wait[i];
    end
    if (last >= 0) m_ptr = (last + 1) % M;
    @(posedge clock);
    #1;
    for (int s = 0; s < N; s++) chk($sformatf("cdb_slot%0d", s), cdb_packet[s], ex[s]);
    chk("max_wait", max_wait, m_max);
  endtask

  // Assert reset now (any phase), check the asynchronous effect, release
  // one time unit after the next posedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_slot0", cdb_packet[0], 0);
    chk("rst_slot1", cdb_packet[1], 0);
    chk("rst_max_wait", max_wait, 0);
    chk("rst_grant", req_grant, 0);
    @(posedge clock);
    #1;
    chk("rst_grant_held", req_grant, 0);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [M-1:0] v;
    logic         sq;
    logic [M-1:0] g;
    int           s0;
    int           s1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{6'b111111, 1'b0, 6'b000011, 0, 1};
    tbl[1] = '{6'b111111, 1'b0, 6'b001100, 2, 3};
    tbl[2] = '{6'b111111, 1'b0, 6'b110000, 4, 5};
    tbl[3] = '{6'b010000, 1'b0, 6'b010000, 4, -1};   // ptr -> 5
    tbl[4] = '{6'b100001, 1'b0, 6'b100001, 5, 0};    // wrap, ptr -> 1
    tbl[5] = '{6'b000011, 1'b0, 6'b000011, 1, 0};    // ptr was 1
    tbl[6] = '{6'b111111, 1'b1, 6'b000000, -1, -1};  // squash
    tbl[7] = '{6'b111111, 1'b0, 6'b000110, 1, 2};    // ptr kept at 1
    tbl[8] = '{6'b000000, 1'b0, 6'b000000, -1, -1};
    tbl[9] = '{6'b000001, 1'b0, 6'b000001, 0, -1};

    for (int i = 0; i < M; i++)
      pk[i] = '{valid: 1'b0, robn: 5'(i + 1), dest_prn: 6'(i + 10), value: 32'hA000 + i};
    vin  = '0;
    sqin = 1'b0;
    drive();
    #3;
    do_reset();

    // Directed table
    for (int r = 0; r < 10; r++) begin
      vin  = tbl[r].v;
      sqin = tbl[r].sq;
      drive();
      step();
      chk($sformatf("tbl%0d_grant", r), got_g, tbl[r].g);
      chk($sformatf("tbl%0d_slot0", r), cdb_packet[0], slot_pkt(tbl[r].s0));
      chk($sformatf("tbl%0d_slot1", r), cdb_packet[1], slot_pkt(tbl[r].s1));
    end
    chk("tbl_max_wait", max_wait, 8'd2);

    // Single request with dest_prn 0 still broadcasts
    pk[3] = '{valid: 1'b1, robn: 5'd7, dest_prn: 6'd0, value: 32'hDEAD};
    vin = 6'b001000; sqin = 1'b0;
    drive();
    step();
    chk("prn0_valid", cdb_packet[0].valid, 1);
    chk("prn0_value", cdb_packet[0].value, 32'hDEAD);
    chk("prn0_slot1_invalid", cdb_packet[1].valid, 0);

    // Async reset mid-cycle with four pending
    vin = 6'b011110;
    drive();
    step();
    vin = vin & ~ex_g;
    drive();
    #3;
    do_reset();
    chk("rst_cdb_after_edge", cdb_packet, 0);
    vin = 6'b111111;
    drive();
    step();
    chk("post_rst_grant", got_g, 6'b000011);

    // Continuous full load, refilled after each grant
    for (int c = 0; c < 10; c++) begin
      vin = 6'b111111;
      drive();
      step();
    end
    chk("fair_max_wait", max_wait <= 8'd2, 1);

    // Randomised traffic obeying hold-until-granted
    vin = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < M; i++) begin
        if (!vin[i] && $urandom_range(1, 0) == 1) begin
          vin[i] = 1'b1;
          pk[i].valid    = 1'($urandom_range(1, 0));
          pk[i].robn     = 5'($urandom_range(31, 0));
          pk[i].dest_prn = ($urandom_range(3, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 0));
          pk[i].value    = $urandom;
        end
      end
      sqin = ($urandom_range(15, 0) == 0);
      drive();
      step();
      vin = vin & ~ex_g;
    end
    chk("rand_fair_max_wait", max_wait <= 8'd2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
